// File: rtl/channel_grant_decoder_pkg.sv
// Shared types and defaults for the Merak channel grant decoder.
// N/IW match the 32-to-5 priority encoder on the arbitration side.
package channel_grant_decoder_pkg;

  localparam int unsigned CGD_N  = 32;
  localparam int unsigned CGD_IW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } cgd_state_e;

  function automatic logic idx_in_range(
    input int unsigned idx,
    input int unsigned n
  );
    return idx < n;
  endfunction

endpackage

// File: rtl/channel_grant_decoder_onehot_decoder.sv
// Combinational IW-to-N one-hot decode with range flag.
// Out-of-range indices decode to all-zero.
module onehot_decoder
  import channel_grant_decoder_pkg::*;
#(
  parameter int N  = CGD_N,
  parameter int IW = CGD_IW
) (
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          in_range
);

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx);

  always_comb begin
    onehot   = '0;
    in_range = idx_in_range(idx_ext, N);
    for (int i = 0; i < N; i++) begin
      if (idx_ext == 32'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_grant_decoder.sv
// Sequential 5-to-32 grant decoder: registered one-hot grant
// held until done[cur_idx] or a hold timeout, then one gap cycle.
module channel_grant_decoder
  import channel_grant_decoder_pkg::*;
#(
  parameter int N       = CGD_N,
  parameter int IW      = CGD_IW,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] in_idx,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] cur_idx,
  output logic          timeout,
  output logic          idx_err
);

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  cgd_state_e    state;
  logic [TW-1:0] cnt;
  logic [N-1:0]  dec_onehot;
  logic          dec_ok;
  logic          xfer;
  logic          done_cur;

  onehot_decoder #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .idx      (in_idx),
    .onehot   (dec_onehot),
    .in_range (dec_ok)
  );

  assign in_ready = (state == IDLE);
  assign xfer     = in_valid & in_ready;

  // cur_idx is always in range while in GRANT
  always_comb begin
    done_cur = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(cur_idx) == 32'(i)) begin
        done_cur = done[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      cur_idx     <= '0;
      timeout     <= 1'b0;
      idx_err     <= 1'b0;
      cnt         <= '0;
    end else begin
      timeout <= 1'b0;
      idx_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (dec_ok) begin
              cur_idx     <= in_idx;
              grant       <= dec_onehot;
              grant_valid <= 1'b1;
              cnt         <= '0;
              state       <= GRANT;
            end else begin
              idx_err <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (done_cur) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= RELEASE;
          end else if (cnt == CNT_LAST) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_grant_decoder.sv
// Bench for channel_grant_decoder: directed cases plus random
// transactions predicted from grant-length / timeout rules.
module tb_channel_grant_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_idx;
  logic        in_valid;
  logic [31:0] done;
  logic        sel;

  logic        rdy0, gv0, to0, err0;
  logic [31:0] g0;
  logic [4:0]  ci0;
  logic        rdy1, gv1, to1, err1;
  logic [19:0] g1;
  logic [4:0]  ci1;

  logic [31:0] o_grant;
  logic [4:0]  o_cur;
  logic        o_ready, o_gv, o_to, o_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  channel_grant_decoder u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .in_idx      (in_idx),
    .in_valid    (in_valid & ~sel),
    .in_ready    (rdy0),
    .done        (done),
    .grant       (g0),
    .grant_valid (gv0),
    .cur_idx     (ci0),
    .timeout     (to0),
    .idx_err     (err0)
  );

  channel_grant_decoder #(
    .N       (20),
    .IW      (5),
    .TIMEOUT (4),
    .TW      (8)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .in_idx      (in_idx),
    .in_valid    (in_valid & sel),
    .in_ready    (rdy1),
    .done        (done[19:0]),
    .grant       (g1),
    .grant_valid (gv1),
    .cur_idx     (ci1),
    .timeout     (to1),
    .idx_err     (err1)
  );

  assign o_grant = sel ? {12'b0, g1} : g0;
  assign o_cur   = sel ? ci1 : ci0;
  assign o_ready = sel ? rdy1 : rdy0;
  assign o_gv    = sel ? gv1 : gv0;
  assign o_to    = sel ? to1 : to0;
  assign o_err   = sel ? err1 : err0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: grant lasts min(dlen, T) cycles, timeout iff dlen > T
  task automatic run_txn(input int idx, input int dlen,
                         input logic [31:0] noise);
    int          n;
    int          t;
    int          glen;
    logic        to_exp;
    logic [31:0] bit_m;
    n     = sel ? 20 : 32;
    t     = sel ? 4 : 255;
    bit_m = 32'd1 << idx;
    chk("ready_before", 32'(o_ready), 32'd1);
    in_idx   = 5'(idx);
    in_valid = 1'b1;
    done     = '0;
    @(negedge clk);
    in_valid = 1'b0;
    if (idx >= n) begin
      chk("oob_err", 32'(o_err), 32'd1);
      chk("oob_grant", o_grant, 32'd0);
      chk("oob_gv", 32'(o_gv), 32'd0);
      chk("oob_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      chk("oob_err_clr", 32'(o_err), 32'd0);
      chk("oob_grant2", o_grant, 32'd0);
      return;
    end
    glen   = (dlen <= t) ? dlen : t;
    to_exp = (dlen > t);
    for (int c = 1; c <= glen; c++) begin
      if (c > 1) @(negedge clk);
      chk("grant", o_grant, bit_m);
      chk("gv", 32'(o_gv), 32'd1);
      chk("cur_idx", 32'(o_cur), 32'(idx));
      chk("busy_ready", 32'(o_ready), 32'd0);
      chk("busy_to", 32'(o_to), 32'd0);
      if (c == dlen) done = bit_m | noise;
      else if ((c % 2) == 1) done = noise & ~bit_m;
      else done = '0;
    end
    @(negedge clk);
    done = '0;
    chk("rel_grant", o_grant, 32'd0);
    chk("rel_gv", 32'(o_gv), 32'd0);
    chk("rel_ready", 32'(o_ready), 32'd0);
    chk("rel_to", 32'(o_to), 32'(to_exp));
    chk("rel_err", 32'(o_err), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(o_ready), 32'd1);
    chk("idle_to", 32'(o_to), 32'd0);
    chk("idle_grant", o_grant, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 1'b0;
    in_idx   = 5'd2;
    in_valid = 1'b1;
    done     = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_grant", g0, 32'd0);
      chk("rst_to", 32'(to0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_grant1", 32'(g1), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_cur", 32'(ci0), 32'd0);

    run_txn(17, 4, 32'd0);
    run_txn(3, 6, 32'h10);
    run_txn(31, 300, 32'd0);

    sel = 1'b1;
    run_txn(0, 99, 32'd0);
    run_txn(7, 4, 32'd0);
    run_txn(25, 1, 32'd0);
    run_txn(19, 1, 32'hffff_ffff);

    // reset while channel 9 is granted
    sel      = 1'b0;
    in_idx   = 5'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_grant", g0, 32'h200);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", g0, 32'd0);
    chk("mid_rst_gv", 32'(gv0), 32'd0);
    chk("mid_rst_to", 32'(to0), 32'd0);
    chk("mid_rst_ready", 32'(rdy0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy0), 32'd1);
    chk("post_rst_to", 32'(to0), 32'd0);

    for (int k = 0; k < 60; k++) begin
      sel = 1'($urandom_range(0, 1));
      run_txn(int'($urandom_range(0, 31)),
              int'($urandom_range(1, sel ? 6 : 12)),
              $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
